// File: rtl/fbuf_pixel_pipe.sv
// Framebuffer pixel pipeline: BRAM read request, palette lookup, sync alignment and bank swap.
// Define FBUF_PIXEL_PIPE_PALETTE_EN for a writable palette; otherwise indices expand to grayscale.
module fbuf_pixel_pipe #(
    parameter int FBUF_ADDR_WIDTH = 8,
    parameter int PIXEL_WIDTH     = 4,
    parameter int READ_LATENCY    = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       hsync_in,
    input  logic                       vsync_in,
    input  logic                       vde_in,
    input  logic                       eof_in,
    input  logic [FBUF_ADDR_WIDTH-1:0] pixel_fbuf_address,
    output logic                       fbuf_rd_en,
    output logic [FBUF_ADDR_WIDTH:0]   fbuf_rd_addr,
    input  logic [PIXEL_WIDTH-1:0]     fbuf_rd_data,
    input  logic                       swap_req,
    output logic                       swap_ack,
    output logic                       display_bank,
    input  logic                       pal_wr_en,
    input  logic [PIXEL_WIDTH-1:0]     pal_wr_addr,
    input  logic [23:0]                pal_wr_data,
    output logic [23:0]                rgb,
    output logic                       hsync_out,
    output logic                       vsync_out,
    output logic                       vde_out
);

    localparam int L = READ_LATENCY + 2;

    typedef enum logic {
        S_IDLE,
        S_PENDING
    } swap_state_t;

    swap_state_t r_swap_state;
    logic [2:0]  r_sync [L];
    logic        w_vde_pal;
    logic [23:0] w_colour;

    // A request arriving with eof_in only arms the swap; the toggle waits for the next eof_in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_swap_state <= S_IDLE;
            display_bank <= 1'b0;
            swap_ack     <= 1'b0;
        end else begin
            swap_ack <= 1'b0;
            case (r_swap_state)
                S_IDLE: begin
                    if (swap_req) r_swap_state <= S_PENDING;
                end
                S_PENDING: begin
                    if (eof_in) begin
                        display_bank <= ~display_bank;
                        swap_ack     <= 1'b1;
                        r_swap_state <= S_IDLE;
                    end
                end
                default: r_swap_state <= S_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fbuf_rd_en   <= 1'b0;
            fbuf_rd_addr <= '0;
        end else begin
            fbuf_rd_en   <= vde_in;
            fbuf_rd_addr <= {display_bank, pixel_fbuf_address};
        end
    end

    // {hsync, vsync, vde} delay line; stage L-2 lines up with returned BRAM data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < L; k++) r_sync[k] <= '0;
        end else begin
            r_sync[0] <= {hsync_in, vsync_in, vde_in};
            for (int k = 1; k < L; k++) r_sync[k] <= r_sync[k-1];
        end
    end

    assign w_vde_pal = r_sync[L-2][0];
    assign {hsync_out, vsync_out, vde_out} = r_sync[L-1];

`ifdef FBUF_PIXEL_PIPE_PALETTE_EN
    logic [23:0] r_palette [2**PIXEL_WIDTH];

    // NOTE: the palette RAM has no reset so it maps onto RAM primitives; software loads it.
    always_ff @(posedge clk) begin
        if (pal_wr_en) r_palette[pal_wr_addr] <= pal_wr_data;
    end

    // Asynchronous read of the pre-edge contents gives read-before-write on a same-cycle hit.
    assign w_colour = r_palette[fbuf_rd_data];
`else
    logic [7:0] w_gray;
    logic       w_unused_pal;

    function automatic logic [7:0] expand_gray(input logic [PIXEL_WIDTH-1:0] idx);
        logic [7:0] g;
        g = '0;
        for (int i = 0; i < 8; i++) g[7-i] = idx[PIXEL_WIDTH-1-(i % PIXEL_WIDTH)];
        return g;
    endfunction

    assign w_gray       = expand_gray(fbuf_rd_data);
    assign w_colour     = {w_gray, w_gray, w_gray};
    assign w_unused_pal = ^{pal_wr_en, pal_wr_addr, pal_wr_data};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rgb <= '0;
        else     rgb <= w_vde_pal ? w_colour : 24'h000000;
    end

endmodule
